gray_to_binary_tracker: RTL
===========================

Name: gray_to_binary_tracker

Overview:
- Receives a Gray-coded WIDTH-bit value (e.g. a counter or pointer) that may be asynchronous to clk.
- Synchronises it through SYNC_STAGES flops, decodes it to binary, and registers the result.
- Flags every change and its direction (up/down), and detects illegal multi-bit Gray transitions.
- Sits on the consumer side of any Gray-encoded count produced elsewhere in the design.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output (>=2)
- SYNC_STAGES, 2, number of synchroniser flops on gray_in (>=2)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- gray_in  input  WIDTH  Gray-coded value, may be asynchronous to clk
- clear_err  input  1  synchronous clear of err_count
- bin_out  output  WIDTH  registered decoded binary value
- bin_valid  output  1  high once bin_out holds a decoded sample
- changed  output  1  one-cycle pulse: decoded value differs from previous
- dir_up  output  1  one-cycle pulse with changed: legal step of +1 mod 2^WIDTH
- step_err  output  1  one-cycle pulse: Gray transition flipped more than 1 bit
- err_count  output  ERR_CNT_W  saturating count of step_err pulses

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, bin_out, previous-Gray register, bin_valid, changed, dir_up, step_err and err_count go to 0 immediately and stay 0 while rst_n is low.
- Synchroniser: sync[0] <= gray_in; sync[i] <= sync[i-1]; g = sync[SYNC_STAGES-1]. No logic between the sync flops.
- Decode (combinational from g): b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- Output register: bin_out <= b every cycle.
- Latency: when gray_in is stable before rising edge n, bin_out reflects it after edge n+SYNC_STAGES, i.e. SYNC_STAGES+1 edges.
- Priming:
  - Internal flag "primed" is 0 out of reset.
  - The first edge after rst_n deassertion at which g has passed through all sync stages (edge index SYNC_STAGES, counting from 0) loads bin_out and prev_g, and sets bin_valid=1 and primed=1.
  - changed, dir_up and step_err stay 0 on this priming edge.
  - bin_valid then stays 1 until the next reset.
- Change detection when primed, registered alongside bin_out:
  - d = g ^ prev_g; changed <= (d != 0).
  - step_err <= (popcount(d) > 1).
  - dir_up <= changed & ~step_err & (b == prev_b + 1 mod 2^WIDTH).
  - When popcount(d) == 1 and dir_up == 0, the step is -1 (down).
  - prev_g <= g every cycle; prev_b is the current bin_out.
- Illegal transition: bin_out still updates to the decoded value; step_err pulses once; changed also pulses.
- Wrap-around:
  - max -> 0, i.e. Gray 1000 -> 0000 for WIDTH=4, is a legal +1: dir_up=1.
  - 0 -> max is a legal -1: dir_up=0, changed=1.
- No change: changed, dir_up and step_err are 0 and bin_out holds.
- err_count:
  - Increments by 1 on each step_err pulse and saturates at 2^ERR_CNT_W-1.
  - clear_err sets it to 0 on the next edge.
  - If clear_err and step_err coincide, err_count becomes 1.
- Reset mid-operation: asynchronous return to the reset state; priming repeats after release.
- Held values: outputs are pulses, not sticky (except err_count and bin_valid).

Test Plan:
- Reset/priming: hold gray_in=0111, release rst_n -> bin_valid and bin_out=0101 appear after the 3rd rising edge (index 2); changed=step_err=0 on that edge; all outputs 0 during reset.
- Count up through all 16 codes, one Gray step every 4 cycles -> each bin_out change lags gray_in by 3 edges; changed=1 and dir_up=1 single-cycle pulses; wrap 1000->0000 gives bin_out 1111->0000 with dir_up=1; err_count=0.
- Count down 0000->1000->1001 -> bin_out 0->15->14; changed pulses, dir_up=0, step_err=0.
- Illegal jump 0000->0011 -> bin_out=0010, changed=1, step_err=1, dir_up=0, err_count=1; repeat 300 illegal jumps -> err_count saturates at 255; clear_err coincident with a step_err -> err_count=1.
- Stable input 0110 for 20 cycles after priming -> bin_out=0100 constant, no pulses.
- Assert rst_n low mid-count (bin_out=1010) -> all outputs 0 immediately, without a clock edge; after release, priming repeats with no spurious changed or step_err.

Source files
------------

// File: rtl/gray_to_binary_tracker.sv
// Synchronises an asynchronous Gray-coded value, decodes it to binary and
// reports each change with its direction, plus illegal multi-bit Gray steps.
module gray_to_binary_tracker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 changed,
    output logic                 dir_up,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    logic [WIDTH-1:0]       sync_reg [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   primed_reg;
    logic [WIDTH-1:0]       prev_g_reg;
    logic [WIDTH-1:0]       bin_out_reg;
    logic                   bin_valid_reg;
    logic                   changed_reg;
    logic                   dir_up_reg;
    logic                   step_err_reg;
    logic [ERR_CNT_W-1:0]   err_count_reg;

    logic [WIDTH-1:0]       g;
    logic [WIDTH-1:0]       b;
    logic [WIDTH-1:0]       d;
    logic [WIDTH-1:0]       prev_b_inc;
    logic                   changed_next;
    logic                   step_err_next;
    logic                   dir_up_next;
    logic                   err_event;

    // Plain flop chain: nothing may sit between the metastability stages.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= gray_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign g = sync_reg[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign b[gi] = ^g[WIDTH-1:gi];
        end
    endgenerate

    assign d             = g ^ prev_g_reg;
    assign prev_b_inc    = bin_out_reg + 1'b1;
    assign changed_next  = (d != '0);
    // More than one bit set iff clearing the lowest set bit leaves something.
    assign step_err_next = ((d & (d - 1'b1)) != '0);
    assign dir_up_next   = changed_next & ~step_err_next & (b == prev_b_inc);
    assign err_event     = primed_reg & step_err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg      <= '0;
            primed_reg    <= 1'b0;
            prev_g_reg    <= '0;
            bin_out_reg   <= '0;
            bin_valid_reg <= 1'b0;
            changed_reg   <= 1'b0;
            dir_up_reg    <= 1'b0;
            step_err_reg  <= 1'b0;
            err_count_reg <= '0;
        end else begin
            fill_reg    <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
            bin_out_reg <= b;
            prev_g_reg  <= g;

            if (primed_reg) begin
                changed_reg  <= changed_next;
                step_err_reg <= step_err_next;
                dir_up_reg   <= dir_up_next;
            end else begin
                changed_reg  <= 1'b0;
                step_err_reg <= 1'b0;
                dir_up_reg   <= 1'b0;
                if (fill_reg[SYNC_STAGES-1]) begin
                    primed_reg    <= 1'b1;
                    bin_valid_reg <= 1'b1;
                end
            end

            // A clear on the same edge as an error leaves that error counted.
            if (clear_err) begin
                err_count_reg <= err_event ? ERR_CNT_W'(1) : '0;
            end else if (err_event && (err_count_reg != ERR_MAX)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

    assign bin_out   = bin_out_reg;
    assign bin_valid = bin_valid_reg;
    assign changed   = changed_reg;
    assign dir_up    = dir_up_reg;
    assign step_err  = step_err_reg;
    assign err_count = err_count_reg;

endmodule
